// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the Gray counter and its downstream converter.
// Both functions work on zero-extended words, so any WIDTH up to MAX_WIDTH can use them.
package gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_WIDTH     = 32;

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the low WIDTH bits exact.
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_step.sv
// Combinational next binary count: one step up or down, wrapping or saturating at the ends.
module gray_step
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter bit          WRAP  = 1'b1
) (
  input  logic [WIDTH-1:0] b,
  input  logic             up,
  output logic [WIDTH-1:0] b_next
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // NOTE: default assigned first so every path drives b_next and no latch is inferred.
  always_comb begin
    b_next = b;
    if (up) begin
      if (b != MAX)  b_next = b + WIDTH'(1);
      else if (WRAP) b_next = '0;
    end else begin
      if (b != '0)   b_next = b - WIDTH'(1);
      else if (WRAP) b_next = MAX;
    end
  end

endmodule

// File: rtl/gray_counter.sv
// Gray-code up/down counter with load, terminal-count flag and a valid/ready output.
// Counts in binary; the presented Gray word is registered alongside the count.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] g,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] g_q;
  logic             valid_q;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] b_load;
  logic             transfer;

  gray_step #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_step (
    .b      (b_q),
    .up     (up),
    .b_next (b_next)
  );

  assign b_load   = WIDTH'(gray2bin(MAX_WIDTH'(load_gray)));
  assign transfer = valid_q & out_ready;

  // Priority: rst > load > transfer > issue > hold. An issue never steps the count.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      b_q     <= b_load;
      g_q     <= load_gray;
      valid_q <= 1'b1;
    end else if (transfer) begin
      b_q     <= b_next;
      g_q     <= WIDTH'(bin2gray(MAX_WIDTH'(b_next)));
      valid_q <= en;
    end else if (!valid_q && en) begin
      valid_q <= 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign g         = g_q;
  assign tc        = valid_q & ((up & (b_q == MAX)) | (!up & (b_q == '0)));

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench: wrapping and saturating counters share stimulus; a reference model queues
// the expected outputs per cycle and a negedge monitor pops and compares them.
module tb_gray_counter;

  localparam int W      = 4;
  localparam int NWORDS = 1 << W;
  localparam int MAXV   = NWORDS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0, out_ready = 1'b0;
  logic [W-1:0] load_gray = '0;
  logic valid_w, tc_w, valid_s, tc_s;
  logic [W-1:0] g_w, g_s;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .out_ready(out_ready), .out_valid(valid_w), .g(g_w), .tc(tc_w));

  gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .out_ready(out_ready), .out_valid(valid_s), .g(g_s), .tc(tc_s));

  typedef struct {
    logic         v0, v1;
    logic         tc0, tc1;
    logic [W-1:0] g0, g1;
  } exp_t;

  exp_t exp_q[$];
  logic [W-1:0] acc_q[$];
  bit rec = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference state per instance: index 0 wraps, index 1 saturates.
  int m_cnt[2];
  bit m_val[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int gray_of(input int n);
    return n ^ (n >> 1);
  endfunction

  function automatic int index_of_gray(input int gw);
    for (int n = 0; n < NWORDS; n++) if (gray_of(n) == gw) return n;
    return 0;
  endfunction

  function automatic int step(input int c, input bit u, input bit wrap);
    int s;
    s = u ? c + 1 : c - 1;
    if (wrap) return (s + NWORDS) % NWORDS;
    if (s < 0) return 0;
    if (s > MAXV) return MAXV;
    return s;
  endfunction

  function automatic bit tc_of(input int k, input bit u);
    return m_val[k] && ((u && m_cnt[k] == MAXV) || (!u && m_cnt[k] == 0));
  endfunction

  // Advance the model with the inputs the DUT just sampled.
  task automatic model_update(input int k);
    if (rst) begin
      m_cnt[k] = 0;
      m_val[k] = 1'b0;
    end else if (load) begin
      m_cnt[k] = index_of_gray(int'(load_gray));
      m_val[k] = 1'b1;
    end else if (m_val[k] && out_ready) begin
      m_cnt[k] = step(m_cnt[k], up, (k == 0));
      m_val[k] = en;
    end else if (!m_val[k] && en) begin
      m_val[k] = 1'b1;
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit u, input bit l,
                       input int lg, input bit rd);
    exp_t x;
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    rst = r; en = e; up = u; load = l; load_gray = W'(lg); out_ready = rd;
    x.v0  = m_val[0];
    x.v1  = m_val[1];
    x.g0  = W'(gray_of(m_cnt[0]));
    x.g1  = W'(gray_of(m_cnt[1]));
    x.tc0 = tc_of(0, u);
    x.tc1 = tc_of(1, u);
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("valid_wrap", int'(valid_w), int'(e.v0));
      check("g_wrap",     int'(g_w),     int'(e.g0));
      check("tc_wrap",    int'(tc_w),    int'(e.tc0));
      check("valid_sat",  int'(valid_s), int'(e.v1));
      check("g_sat",      int'(g_s),     int'(e.g1));
      check("tc_sat",     int'(tc_s),    int'(e.tc1));
      if (rec && valid_w && out_ready) acc_q.push_back(g_w);
    end
  end

  int seq1[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    // Reset, then free-running count up with the wrapping sequence recorded.
    repeat (2) drive(1, 0, 1, 0, 0, 1);
    rec = 1'b1;
    repeat (18) drive(0, 1, 1, 0, 0, 1);
    @(negedge clk);
    #1;
    rec = 1'b0;
    check("seq1_len", acc_q.size(), 17);
    for (int i = 0; i < 17 && i < acc_q.size(); i++)
      check($sformatf("seq1_word%0d", i), int'(acc_q[i]), seq1[i]);

    // Saturation at both ends.
    repeat (10) drive(0, 1, 1, 0, 0, 1);
    repeat (20) drive(0, 1, 0, 0, 0, 1);

    // Backpressure on 0011, then release.
    drive(0, 1, 1, 1, 'b0011, 0);
    repeat (3) drive(0, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 1, 1, 0, 0, 1);

    // Load 0110 and count down through the wrap.
    drive(0, 1, 0, 1, 'b0110, 1);
    repeat (7) drive(0, 1, 0, 0, 0, 1);

    // Load over a pending word, load together with a transfer, reset mid-stream.
    drive(0, 1, 1, 1, 'b0101, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 'b1111, 0);
    drive(0, 1, 1, 1, 'b1010, 1);
    repeat (2) drive(0, 1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1);
    repeat (3) drive(0, 1, 1, 0, 0, 1);

    // en low on the transfer of 0010, later re-enabled.
    drive(0, 1, 1, 1, 'b0011, 0);
    drive(0, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 1);
    repeat (2) drive(0, 0, 1, 0, 0, 1);
    repeat (3) drive(0, 1, 1, 0, 0, 1);

    // Randomised traffic.
    repeat (3000)
      drive(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, NWORDS - 1)), 1'($urandom_range(0, 3) != 0));

    repeat (2) drive(0, 0, 1, 0, 0, 1);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
